// File: rtl/aes_round_key_store.sv
// aes_round_key_store
// Collects the serial AES key-schedule byte stream (MSB first) into eleven
// 128-bit round keys and serves them through a registered read port. A
// per-slot valid mask gates reads, so the key storage itself is never cleared.
module aes_round_key_store #(
    parameter int NUM_ROUNDS = 11,
    parameter int BYTE_W     = 8,
    parameter int KEY_W      = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              key_valid,
    input  logic [BYTE_W-1:0] key_byte,
    input  logic [3:0]        rd_round,
    output logic [KEY_W-1:0]  rd_key,
    output logic              keys_ready,
    output logic              busy,
    output logic [3:0]        wr_round
);

    localparam int         BYTES_PER_KEY = KEY_W / BYTE_W;
    localparam logic [3:0] LAST_BYTE     = 4'(BYTES_PER_KEY - 1);
    localparam logic [3:0] LAST_ROUND    = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READY
    } state_t;

    state_t state;
    state_t state_next;

    // Only the 15 bytes preceding the current one need to be held; the
    // 16th byte is taken straight from key_byte when the key is written.
    logic [KEY_W-BYTE_W-1:0] shift;
    logic [3:0]              byte_cnt;
    logic [NUM_ROUNDS-1:0]   valid;
    logic [KEY_W-1:0]        key_mem [NUM_ROUNDS];

    logic take_byte;
    logic key_done;
    logic last_key;
    logic rd_hit;

    // Decode this cycle's capture events; start always wins over key_valid.
    always_comb begin
        take_byte = (state == CAPTURE) && key_valid && !start;
        key_done  = take_byte && (byte_cnt == LAST_BYTE);
        last_key  = key_done && (wr_round == LAST_ROUND);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, regardless of block ordering.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        busy       = 1'b0;
        keys_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (start) begin
                    state_next = CAPTURE;
                end else if (last_key) begin
                    state_next = READY;
                end
            end
            READY: begin
                keys_ready = 1'b1;
                if (start) state_next = CAPTURE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte assembly, write index and valid mask; start restarts from scratch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift    <= '0;
            byte_cnt <= '0;
            wr_round <= '0;
            valid    <= '0;
        end else if (start) begin
            shift    <= '0;
            byte_cnt <= '0;
            wr_round <= '0;
            valid    <= '0;
        end else if (take_byte) begin
            shift <= {shift[KEY_W-2*BYTE_W-1:0], key_byte};
            if (key_done) begin
                byte_cnt        <= '0;
                valid[wr_round] <= 1'b1;
                // Saturate on the final slot so the index never wraps to 0.
                if (wr_round != LAST_ROUND) begin
                    wr_round <= wr_round + 4'd1;
                end
            end else begin
                byte_cnt <= byte_cnt + 4'd1;
            end
        end
    end

    // Key storage write on the 16th byte of each key.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the valid mask hides any
        // stale contents, and leaving it out lets the array map to RAM.
        if (key_done) begin
            key_mem[wr_round] <= {shift, key_byte};
        end
    end

    // A slot is readable only if in range and already captured before this edge.
    always_comb begin
        rd_hit = 1'b0;
        if (rd_round <= LAST_ROUND) begin
            rd_hit = valid[rd_round];
        end
    end

    // Registered read port, one-cycle latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_key <= '0;
        end else if (rd_hit) begin
            rd_key <= key_mem[rd_round];
        end else begin
            rd_key <= '0;
        end
    end

endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Downstream consumer of the 8-bit key-expansion datapath output.
- Collects the serial round-key byte stream into eleven 128-bit round keys (round 0 = cipher key, rounds 1..10).
- Serves the keys to the round datapath through a registered random-access read port.
- Signals when the full schedule is present, so encryption can start without re-running expansion.

Parameters:
- NUM_ROUNDS, 11, number of 128-bit round keys stored (indices 0..NUM_ROUNDS-1).
- BYTE_W, 8, width of the incoming key stream.
- KEY_W, 128, width of one round key (KEY_W/BYTE_W = 16 bytes per key).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: clear valid flags and begin a new capture.
- key_valid  input  1  key_byte carries a valid schedule byte this cycle.
- key_byte  input  8  round-key byte, most significant byte of each key first.
- rd_round  input  4  round-key index to read.
- rd_key  output  128  registered read data for rd_round.
- keys_ready  output  1  all NUM_ROUNDS keys captured.
- busy  output  1  capture in progress.
- wr_round  output  4  index of the key currently being assembled (debug/visibility).

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; byte_cnt=0, wr_round=0, valid mask=0, shift register=0, rd_key=0, keys_ready=0, busy=0. Key storage contents need no clearing; the valid mask gates reads.
- States: IDLE, CAPTURE, READY.
- IDLE: start -> CAPTURE, busy=1, byte_cnt=0, wr_round=0, valid mask cleared. key_valid is ignored in IDLE.
- CAPTURE, per cycle with key_valid=1:
  - shift register <= {shift[119:0], key_byte}; byte_cnt++.
  - When byte_cnt==15, that same edge writes {shift[119:0], key_byte} to slot wr_round, sets valid[wr_round], wr_round++, byte_cnt=0.
  - The first byte received lands in bits 127:120.
- key_valid=0 in CAPTURE: hold all state. Gaps are allowed at any byte position.
- After the write of slot NUM_ROUNDS-1: next state READY, busy=0, keys_ready=1 (visible the cycle after the 176th byte edge). wr_round saturates at NUM_ROUNDS-1; it does not wrap.
- READY: key_valid ignored; keys_ready held at 1 until start or reset.
- start in READY or CAPTURE: abort and restart the same cycle (as from IDLE). keys_ready drops to 0 on that edge; any partial byte in flight is discarded. start has priority over a simultaneous key_valid, and that byte is dropped.
- Read port, one-cycle latency:
  - rd_key <= (rd_round < NUM_ROUNDS && valid[rd_round]) ? key[rd_round] : 0.
  - Reads are legal in every state, including during capture.
  - Read and write to the same slot on the same edge returns the pre-write view: 0 if the slot was not yet valid.
  - rd_round >= NUM_ROUNDS always returns 0.
- busy=1 exactly while in CAPTURE. wr_round always reflects the internal write index.
- No backpressure: the upstream producer may stream one byte per cycle indefinitely.

Test Plan:
- Reset mid-capture: start, 20 bytes, assert rst=0 asynchronously -> keys_ready=0, busy=0, wr_round=0 immediately. After release, reads of rounds 0 and 1 return 0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: full 176-byte schedule streamed contiguously after start -> keys_ready rises 1 cycle after the last byte. rd_round=0 gives 2b7e1516...4f3c; rd_round=1 gives a0fafe1788542cb123a339392a6c7605; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6, each one cycle after rd_round is applied.
- Same schedule with key_valid deasserted on random cycles (~30%) -> identical stored keys. busy stays 1 throughout; keys_ready only after byte 176.
- Mid-capture read: after exactly 16 bytes, rd_round=0 returns the key, rd_round=1 returns 0. Read of slot 1 on the edge of its 16th byte returns 0, and the following read returns the key.
- Restart: in READY, pulse start with key_valid=1 and byte 0xff -> keys_ready=0 next cycle, byte dropped, all reads return 0. A new stream of 176 bytes captures correctly.
- Out-of-range and idle stream: rd_round=11..15 -> rd_key=0. key_valid bursts while in IDLE -> no state change, wr_round stays 0.
